ps2_rx_fifo: RTL and testbench

//  Next-generation PS/2 device-to-host receiver. Runs entirely on the system clock.

---
 rtl/ps2_rx_fifo_pkg.sv | 30 +++
 rtl/ps2_rx_fifo_if.sv | 31 +++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_rx_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
`default_nettype none
//==============================================================================
// Module   : ps2_pkg
// Brief    : Shared PS/2 receiver types: FSM encoding, error codes, frame size.
// Revision : 1.0 - initial release
//==============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        HOLD   = 3'd4
    } ps2_state_t;

    localparam logic [2:0] ERR_PARITY   = 3'b001;
    localparam logic [2:0] ERR_STOP     = 3'b010;
    localparam logic [2:0] ERR_TIMEOUT  = 3'b100;
    localparam logic [2:0] ERR_OVERFLOW = 3'b011;

    localparam int FRAME_BITS = 11;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo_if.sv
`default_nettype none
//==============================================================================
// Module   : ps2_rx_fifo_if
// Brief    : Receive-FIFO read port plus error/inhibit status of the PS/2 receiver.
// Revision : 1.0 - initial release
//==============================================================================
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
) ();

    logic                          rd_en;
    logic [7:0]                    rd_data;
    logic                          empty;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          err_valid;
    logic [2:0]                    err_code;
    logic                          inhibit;

    modport master (
        output rd_en,
        input  rd_data, empty, full, count, err_valid, err_code, inhibit
    );

    modport slave (
        input  rd_en,
        output rd_data, empty, full, count, err_valid, err_code, inhibit
    );

endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
//==============================================================================
// Module   : ps2_line_filter
// Brief    : Two-flop synchroniser plus run-length glitch filter for one PS/2 line.
// Revision : 1.0 - initial release
//==============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_pin,
    output logic      o_level,
    output logic      o_fall
);

    localparam int              c_cw   = $clog2(FILTER_LEN + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(FILTER_LEN - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic            r_fall;
    logic [c_cw-1:0] r_cnt;

    // r_cnt tracks how many consecutive samples have disagreed with the
    // filtered level; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_fall <= 1'b0;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_level <= r_s2;
                r_fall  <= r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cw'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
//==============================================================================
// Module   : ps2_rx_fifo
// Brief    : PS/2 device-to-host frame receiver feeding a show-ahead byte FIFO.
// Revision : 1.0 - initial release
//==============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int INHIBIT_CYCLES = 5000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      ps2_clk_in,
    input  wire logic      ps2_data_in,
    ps2_rx_fifo_if.slave   bus
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_pw = c_aw + 1;
    localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_hw = $clog2(INHIBIT_CYCLES + 1);

    localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(TIMEOUT_CYCLES - 1);
    localparam logic [c_hw-1:0] c_hold_last = c_hw'(INHIBIT_CYCLES - 1);
    localparam logic [c_pw-1:0] c_depth     = c_pw'(FIFO_DEPTH);

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall;
    logic w_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (ps2_clk_in),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (ps2_data_in),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall)
    );

    assign w_unused = w_clk_lvl ^ w_data_fall;

    ps2_state_t      r_state;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [c_tw-1:0] r_tmo;
    logic [c_hw-1:0] r_hold;
    logic            r_err_valid;
    logic [2:0]      r_err_code;
    logic            r_inhibit;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_pw-1:0] r_wr;
    logic [c_pw-1:0] r_rd;

    logic            w_in_frame;
    logic            w_timeout;
    logic            w_frame_ok;
    logic [c_pw-1:0] w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_overflow;

    assign w_in_frame = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
    // A fall arriving on the expiry cycle still counts as in time.
    assign w_timeout  = w_in_frame && !w_clk_fall && (r_tmo == c_tmo_last);
    assign w_frame_ok = (r_state == STOP) && w_clk_fall && w_data_lvl
                        && odd_parity_ok(r_shift, r_par);

    assign w_count    = r_wr - r_rd;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == c_depth);
    assign w_pop      = bus.rd_en && !w_empty;
    assign w_push     = w_frame_ok && (!w_full || w_pop);
    assign w_overflow = w_frame_ok && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_tmo       <= '0;
            r_hold      <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= 3'b000;
            r_inhibit   <= 1'b0;
        end else begin
            r_err_valid <= 1'b0;

            if (w_clk_fall || !w_in_frame) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_tw'(1);
            end

            if (w_overflow) begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_OVERFLOW;
            end

            if (w_timeout) begin
                r_state     <= HOLD;
                r_hold      <= '0;
                r_inhibit   <= 1'b1;
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_TIMEOUT;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_clk_fall && !w_data_lvl) begin
                            r_state <= DATA;
                            r_idx   <= 3'd0;
                        end
                    end
                    DATA: begin
                        if (w_clk_fall) begin
                            r_shift[r_idx] <= w_data_lvl;
                            r_idx          <= r_idx + 3'd1;
                            if (r_idx == 3'd7) begin
                                r_state <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (w_clk_fall) begin
                            r_par   <= w_data_lvl;
                            r_state <= STOP;
                        end
                    end
                    STOP: begin
                        if (w_clk_fall) begin
                            if (!w_data_lvl || !odd_parity_ok(r_shift, r_par)) begin
                                r_state     <= HOLD;
                                r_hold      <= '0;
                                r_inhibit   <= 1'b1;
                                r_err_valid <= 1'b1;
                                r_err_code  <= !w_data_lvl ? ERR_STOP : ERR_PARITY;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        if (r_hold == c_hold_last) begin
                            r_state   <= IDLE;
                            r_inhibit <= 1'b0;
                        end else begin
                            r_hold <= r_hold + c_hw'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // The extra pointer MSB separates full from empty when the indices match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_pw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[c_aw-1:0]] <= r_shift;
        end
    end

    assign bus.rd_data   = w_empty ? 8'h00 : r_mem[r_rd[c_aw-1:0]];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = w_count;
    assign bus.err_valid = r_err_valid;
    assign bus.err_code  = r_err_code;
    assign bus.inhibit   = r_inhibit;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
//==============================================================================
// Module   : tb_ps2_rx_fifo
// Brief    : Directed self-checking bench for the PS/2 receive FIFO.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int c_filter  = 4;
    localparam int c_depth   = 4;
    localparam int c_timeout = 200;
    localparam int c_inhibit = 50;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_fifo_if #(.FIFO_DEPTH(c_depth)) bus ();

    ps2_rx_fifo #(
        .FILTER_LEN     (c_filter),
        .FIFO_DEPTH     (c_depth),
        .TIMEOUT_CYCLES (c_timeout),
        .INHIBIT_CYCLES (c_inhibit)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_data),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errv_cnt       = 0;
    int   inh_cnt        = 0;
    int   err_cyc        = 0;
    int   empty_fall_cyc = 0;
    logic prev_empty     = 1'b1;

    always @(negedge clk) begin
        if (bus.err_valid) begin
            errv_cnt = errv_cnt + 1;
            err_cyc  = cyc;
        end
        if (bus.inhibit) inh_cnt = inh_cnt + 1;
        if (prev_empty && !bus.empty) empty_fall_cyc = cyc;
        prev_empty = bus.empty;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int last_fall_cyc = 0;
    int e0, i0;
    logic [7:0] exp_q [4] = '{8'h02, 8'h03, 8'h04, 8'h06};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        wait_neg(1);
        bus.rd_en = 1'b0;
    endtask

    // Bit period is 40 clk; glitches are 2 clk wide, below the 4-sample filter.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int nbits, input bit glitch, input bit pop_at_stop);
        logic [FRAME_BITS-1:0] f;
        f = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_neg(10);
            ps2_clk       = 1'b0;
            last_fall_cyc = cyc;
            if (pop_at_stop && i == FRAME_BITS - 1) begin
                // Push lands 2+FILTER_LEN+1 = 7 clk after the pin falls.
                wait_neg(6);
                bus.rd_en = 1'b1;
                wait_neg(1);
                bus.rd_en = 1'b0;
                wait_neg(13);
            end else if (glitch) begin
                wait_neg(8);
                ps2_clk = 1'b1;
                wait_neg(2);
                ps2_clk = 1'b0;
                wait_neg(10);
            end else begin
                wait_neg(20);
            end
            ps2_clk = 1'b1;
            if (glitch) begin
                wait_neg(5);
                ps2_clk = 1'b0;
                wait_neg(2);
                ps2_clk = 1'b1;
                wait_neg(3);
            end else begin
                wait_neg(10);
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1, FRAME_BITS, 1'b0, 1'b0);
    endtask

    initial begin
        bus.rd_en = 1'b0;
        wait_neg(3);
        chk("rst_empty",     32'(bus.empty),     32'd1);
        chk("rst_full",      32'(bus.full),      32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_rd_data",   32'(bus.rd_data),   32'h00);
        chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
        chk("rst_err_code",  32'(bus.err_code),  32'd0);
        chk("rst_inhibit",   32'(bus.inhibit),   32'd0);
        rst = 1'b0;
        wait_neg(10);

        // Good frame 0x1C; a pop issued on the push cycle hits an empty FIFO and is ignored.
        e0 = errv_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS, 1'b0, 1'b1);
        wait_neg(20);
        chk("t1_empty",   32'(bus.empty),   32'd0);
        chk("t1_rd_data", 32'(bus.rd_data), 32'h1C);
        chk("t1_count",   32'(bus.count),   32'd1);
        chk("t1_no_err",  32'(errv_cnt - e0), 32'd0);
        chk("t1_latency", 32'(empty_fall_cyc - last_fall_cyc), 32'd7);
        pop();
        chk("t1_pop_empty", 32'(bus.empty), 32'd1);

        // 0xAA needs parity 1; sending 0 is a parity error.
        e0 = errv_cnt; i0 = inh_cnt;
        send_frame(8'hAA, 1'b0, 1'b1, FRAME_BITS, 1'b0, 1'b0);
        wait_neg(80);
        chk("t2_err_code",  32'(bus.err_code), 32'(ERR_PARITY));
        chk("t2_errv_1clk", 32'(errv_cnt - e0), 32'd1);
        chk("t2_inhibit50", 32'(inh_cnt - i0),  32'd50);
        chk("t2_count",     32'(bus.count),     32'd0);

        // 0x55 with correct parity but stop=0.
        e0 = errv_cnt; i0 = inh_cnt;
        send_frame(8'h55, 1'b1, 1'b0, FRAME_BITS, 1'b0, 1'b0);
        wait_neg(80);
        chk("t3_err_code",  32'(bus.err_code), 32'(ERR_STOP));
        chk("t3_errv",      32'(errv_cnt - e0), 32'd1);
        chk("t3_inhibit50", 32'(inh_cnt - i0),  32'd50);
        chk("t3_empty",     32'(bus.empty),     32'd1);

        // Start + 4 data bits, then silence: 6 clk pin-to-fall, 1 to consume, 200 to expire.
        e0 = errv_cnt; i0 = inh_cnt;
        send_frame(8'h0F, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        wait_neg(300);
        chk("t4_err_code", 32'(bus.err_code), 32'(ERR_TIMEOUT));
        chk("t4_err_time", 32'(err_cyc - last_fall_cyc), 32'd207);
        chk("t4_errv",     32'(errv_cnt - e0), 32'd1);
        chk("t4_inhibit",  32'(inh_cnt - i0),  32'd50);
        chk("t4_count",    32'(bus.count),     32'd0);
        send_good(8'h12);
        wait_neg(20);
        chk("t4_rd_data_12", 32'(bus.rd_data), 32'h12);
        chk("t4_count_12",   32'(bus.count),   32'd1);
        pop();

        // Five frames into a 4-deep FIFO: the fifth overflows.
        e0 = errv_cnt; i0 = inh_cnt;
        for (int b = 1; b <= 5; b++) send_good(8'(b));
        wait_neg(20);
        chk("t5_full",     32'(bus.full),      32'd1);
        chk("t5_count",    32'(bus.count),     32'd4);
        chk("t5_err_code", 32'(bus.err_code),  32'(ERR_OVERFLOW));
        chk("t5_errv",     32'(errv_cnt - e0), 32'd1);
        chk("t5_no_inh",   32'(inh_cnt - i0),  32'd0);
        chk("t5_head",     32'(bus.rd_data),   32'h01);

        // Push and pop together while full: 0x01 leaves, 0x06 enters, no overflow.
        e0 = errv_cnt;
        send_frame(8'h06, ~^8'h06, 1'b1, FRAME_BITS, 1'b0, 1'b1);
        wait_neg(20);
        chk("t5_pp_count", 32'(bus.count),     32'd4);
        chk("t5_pp_noerr", 32'(errv_cnt - e0), 32'd0);
        chk("t5_pp_full",  32'(bus.full),      32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_read%0d", i), 32'(bus.rd_data), 32'(exp_q[i]));
            pop();
        end
        chk("t5_drained", 32'(bus.empty), 32'd1);

        // Glitches on ps2_clk in both phases of every bit.
        e0 = errv_cnt;
        send_frame(8'hC3, ~^8'hC3, 1'b1, FRAME_BITS, 1'b1, 1'b0);
        wait_neg(20);
        chk("t6_rd_data", 32'(bus.rd_data), 32'hC3);
        chk("t6_count",   32'(bus.count),   32'd1);
        chk("t6_noerr",   32'(errv_cnt - e0), 32'd0);

        // Reset mid-frame with 0xC3 queued and err_code=011 standing.
        send_frame(8'h7E, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        wait_neg(5);
        rst = 1'b1;
        #1;
        chk("t7_empty",    32'(bus.empty),    32'd1);
        chk("t7_count",    32'(bus.count),    32'd0);
        chk("t7_full",     32'(bus.full),     32'd0);
        chk("t7_rd_data",  32'(bus.rd_data),  32'h00);
        chk("t7_err_code", 32'(bus.err_code), 32'd0);
        chk("t7_inhibit",  32'(bus.inhibit),  32'd0);
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        wait_neg(5);
        rst = 1'b0;
        wait_neg(10);
        e0 = errv_cnt;
        send_good(8'h7E);
        wait_neg(20);
        chk("t7_rd_data_7e", 32'(bus.rd_data), 32'h7E);
        chk("t7_count_1",    32'(bus.count),   32'd1);
        chk("t7_noerr",      32'(errv_cnt - e0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
